// File: rtl/bar_graph_scan.sv
// bar_graph_scan: time-multiplexed bar-graph scanner (BLANK -> LOAD -> SHOW per channel).
// Define BAR_GRAPH_SCAN_PEAK_HOLD_EN for peak-hold writes with periodic decay.
module bar_graph_scan #(
  parameter int NUM_CH       = 4,
  parameter int IN_WIDTH     = 8,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int DECAY_CYCLES = 65536
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          wr_en,
  input  logic [NUM_CH*IN_WIDTH-1:0] wr_data,
  input  logic                       freeze,
  output logic                       bar_en,
  output logic [IN_WIDTH-1:0]        bar_data,
  output logic [NUM_CH-1:0]          ch_sel
);
  localparam int MX1 = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int MXC = MX1 > DECAY_CYCLES ? MX1 : DECAY_CYCLES;
  localparam int CW  = $clog2(MXC + 1);
  localparam int IW  = $clog2(NUM_CH);
  localparam logic [CW-1:0] DW_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] CH_LAST = IW'(NUM_CH - 1);
  localparam logic [1:0] S_BLANK = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  logic [NUM_CH-1:0][IN_WIDTH-1:0] r_hold;
  logic [1:0]                      r_state;
  logic [CW-1:0]                   r_cnt;
  logic [IW-1:0]                   r_cur;
  logic                            w_last;
  logic                            w_first;
  logic [1:0]                      w_state_nx;
  logic [IW-1:0]                   w_cur_nx;

`ifdef BAR_GRAPH_SCAN_PEAK_HOLD_EN
  localparam logic [CW-1:0] DC_LAST = CW'(DECAY_CYCLES - 1);
  logic [CW-1:0] r_dcnt;
  logic          w_decay;
  assign w_decay = r_dcnt == DC_LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_dcnt <= '0;
    else r_dcnt <= w_decay ? '0 : r_dcnt + 1'b1;
  // A write takes the max and suppresses that channel's decay in the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_hold <= '0;
    else for (int k = 0; k < NUM_CH; k++)
      if (wr_en[k]) r_hold[k] <= wr_data[k*IN_WIDTH +: IN_WIDTH] > r_hold[k] ? wr_data[k*IN_WIDTH +: IN_WIDTH] : r_hold[k];
      else if (w_decay && r_hold[k] != '0) r_hold[k] <= r_hold[k] - 1'b1;
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_hold <= '0;
    else for (int k = 0; k < NUM_CH; k++)
      if (wr_en[k]) r_hold[k] <= wr_data[k*IN_WIDTH +: IN_WIDTH];
`endif

  always_comb begin
    w_first    = r_state == S_BLANK && r_cnt == '0;
    w_last     = r_state == S_BLANK ? r_cnt == BL_LAST : r_state == S_SHOW ? r_cnt == DW_LAST : 1'b1;
    w_state_nx = !w_last ? r_state : r_state == S_BLANK ? S_LOAD : r_state == S_LOAD ? S_SHOW : S_BLANK;
    w_cur_nx   = (w_last && r_state == S_SHOW) ? (r_cur == CH_LAST ? '0 : r_cur + 1'b1) : r_cur;
  end

  // State describes the cycle emitted at the next edge, so outputs come straight from flops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= S_BLANK;
      r_cnt    <= '0;
      r_cur    <= '0;
      bar_en   <= 1'b0;
      bar_data <= '0;
      ch_sel   <= '0;
    end else if (freeze) begin
      bar_en <= 1'b0;
    end else begin
      bar_en   <= w_first || r_state == S_LOAD;
      bar_data <= w_first ? '0 : r_state == S_LOAD ? r_hold[r_cur] : bar_data;
      ch_sel   <= r_state == S_SHOW ? NUM_CH'(1) << r_cur : '0;
      r_state  <= w_state_nx;
      r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
      r_cur    <= w_cur_nx;
    end
endmodule

// File: tb/tb_bar_graph_scan.sv
// tb_bar_graph_scan: directed table, hand sequences and random stimulus against a period-arithmetic model.
module tb_bar_graph_scan;
  localparam int NC = 4, DW = 4, BL = 2, DC = 8, PER = BL + 1 + DW;
  logic clk, rst_n, freeze, bar_en;
  logic [3:0] wr_en, ch_sel;
  logic [31:0] wr_data;
  logic [7:0] bar_data;
  int errors = 0, checks = 0;
  int t, e;
  logic [7:0] mh [NC];
  logic x_en;
  logic [7:0] x_data;
  logic [3:0] x_sel;
`ifdef BAR_GRAPH_SCAN_PEAK_HOLD_EN
  localparam logic [7:0] D = 8'd1;
`else
  localparam logic [7:0] D = 8'd0;
`endif

  bar_graph_scan #(.NUM_CH(NC), .IN_WIDTH(8), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL), .DECAY_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .freeze(freeze),
    .bar_en(bar_en), .bar_data(bar_data), .ch_sel(ch_sel));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic [3:0] we);
    @(negedge clk);
    rst_n = 0; wr_en = we; wr_data = '1; freeze = 0;
    for (int k = 0; k < NC; k++) mh[k] = 0;
    t = 0; e = 0; x_en = 0; x_data = 0; x_sel = 0;
    repeat (2) @(negedge clk);
    check("rst_bar_en", bar_en, 0);
    check("rst_bar_data", bar_data, 0);
    check("rst_ch_sel", ch_sel, 0);
    wr_en = 0; rst_n = 1;
  endtask

  // Expected outputs follow from the unfrozen cycle count: position in channel period and channel number
  task automatic tick(input logic frz, input logic [3:0] we, input logic [31:0] wd);
    int p, ch;
    logic dec;
    freeze = frz; wr_en = we; wr_data = wd;
    @(posedge clk);
    if (!frz) begin
      p = t % PER; ch = (t / PER) % NC;
      x_en = (p == 0) || (p == BL);
      if (p == 0) x_data = 0;
      if (p == BL) x_data = mh[ch];
      x_sel = (p > BL) ? 4'(1 << ch) : 4'b0;
      t++;
    end else x_en = 0;
    dec = (e % DC) == DC - 1;
    e++;
    for (int k = 0; k < NC; k++) begin
`ifdef BAR_GRAPH_SCAN_PEAK_HOLD_EN
      if (we[k]) mh[k] = wd[k*8 +: 8] > mh[k] ? wd[k*8 +: 8] : mh[k];
      else if (dec && mh[k] != 0) mh[k] = mh[k] - 1;
`else
      if (we[k]) mh[k] = wd[k*8 +: 8];
      if (dec) mh[k] = mh[k];
`endif
    end
    @(negedge clk);
    check("m_bar_en", bar_en, x_en);
    check("m_bar_data", bar_data, x_data);
    check("m_ch_sel", ch_sel, x_sel);
  endtask

  typedef struct {int cyc; logic [3:0] we; logic [31:0] wd; logic en; logic [7:0] data; logic [3:0] sel;} vec_t;
  vec_t tbl [15];

  initial begin
    int ti;
    logic [3:0] we;
    logic [31:0] wd;
    rst_n = 0; wr_en = 0; wr_data = 0; freeze = 0;
    tbl[0]  = '{0,  4'hf, 32'h44332211, 1, 8'h00, 4'h0};
    tbl[1]  = '{1,  4'h0, 32'h0, 0, 8'h00, 4'h0};
    tbl[2]  = '{2,  4'h0, 32'h0, 1, 8'h11, 4'h0};
    tbl[3]  = '{3,  4'h0, 32'h0, 0, 8'h11, 4'h1};
    tbl[4]  = '{6,  4'h0, 32'h0, 0, 8'h11, 4'h1};
    tbl[5]  = '{7,  4'h0, 32'h0, 1, 8'h00, 4'h0};
    tbl[6]  = '{9,  4'h0, 32'h0, 1, 8'h22 - D, 4'h0};
    tbl[7]  = '{10, 4'h0, 32'h0, 0, 8'h22 - D, 4'h2};
    tbl[8]  = '{11, 4'h2, 32'h00009900, 0, 8'h22 - D, 4'h2};
    tbl[9]  = '{13, 4'h0, 32'h0, 0, 8'h22 - D, 4'h2};
    tbl[10] = '{24, 4'h0, 32'h0, 0, 8'h44 - 2*D, 4'h8};
    tbl[11] = '{27, 4'h0, 32'h0, 0, 8'h44 - 2*D, 4'h8};
    tbl[12] = '{28, 4'h0, 32'h0, 1, 8'h00, 4'h0};
    tbl[13] = '{31, 4'h0, 32'h0, 0, 8'h11 - 3*D, 4'h1};
    tbl[14] = '{37, 4'h0, 32'h0, 1, 8'h99 - 3*D, 4'h0};

    do_reset(4'h0);
    ti = 0;
    for (int c = 0; c <= 40; c++) begin
      we = 0; wd = 0;
      if (ti < 15 && tbl[ti].cyc == c) begin we = tbl[ti].we; wd = tbl[ti].wd; end
      tick(0, we, wd);
      if (ti < 15 && tbl[ti].cyc == c) begin
        check($sformatf("tbl%0d_en", c), bar_en, tbl[ti].en);
        check($sformatf("tbl%0d_data", c), bar_data, tbl[ti].data);
        check($sformatf("tbl%0d_sel", c), ch_sel, tbl[ti].sel);
        ti++;
      end
    end

    do_reset(4'h0);
    tick(0, 4'hf, 32'h44332211);
    for (int c = 1; c <= 17; c++) begin
      tick(c >= 4 && c <= 13, 4'h0, 32'h0);
      if (c == 9) begin check("frz_sel", ch_sel, 4'h1); check("frz_en", bar_en, 0); end
      if (c == 16) check("frz_show_end", ch_sel, 4'h1);
      if (c == 17) begin check("frz_blank_en", bar_en, 1); check("frz_blank_sel", ch_sel, 0); end
    end

    do_reset(4'hf);
    tick(0, 4'hf, 32'h44332211);
    for (int c = 1; c <= 3; c++) tick(0, 4'h0, 32'h0);
    #2 rst_n = 0;
    #1 check("async_sel", ch_sel, 0);
    check("async_en", bar_en, 0);
    do_reset(4'hf);
    for (int c = 0; c < NC * PER; c++) begin
      tick(0, 4'h0, 32'h0);
      if (c % PER == BL) check($sformatf("post_rst_load%0d", c), bar_data, 0);
    end

`ifdef BAR_GRAPH_SCAN_PEAK_HOLD_EN
    do_reset(4'h0);
    tick(0, 4'h1, 32'h10);
    tick(0, 4'h1, 32'h05);
    tick(0, 4'h0, 32'h0);
    check("peak_load", bar_data, 8'h10);
    for (int c = 3; c <= 30; c++) tick(0, 4'h0, 32'h0);
    check("peak_decay", bar_data, 8'h0d);
    for (int c = 31; c < 400; c++) tick(0, 4'h0, 32'h0);
`endif

    do_reset(4'h0);
    for (int c = 0; c < 700; c++)
      tick($urandom_range(0, 99) < 15, 4'($urandom), $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
